// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: buffers up to DEPTH ALU commands, then on start clears
// the ALU accumulator, issues one command per clock, watches the ALU error
// code and returns the final accumulator with a one-cycle done pulse.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command push handshake
//   cmd_op, cmd_p, cmd_q         command fields {op, P, Q}
//   start                        begin a run (sampled only in IDLE)
//   alu_op, alu_p, alu_q         registered drive to the ALU
//   alu_out, alu_err             ALU accumulator and error code
//   busy, done, result, err      run status and final outcome
module calc_op_sequencer #(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] CLR_OP = 4'b1100,
    parameter logic [3:0] NOP_OP = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_p,
    input  logic [31:0] cmd_q,
    input  logic        start,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_p,
    output logic [31:0] alu_q,
    input  logic [31:0] alu_out,
    input  logic [1:0]  alu_err,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_p_q, alu_p_d;
    logic [31:0] alu_q_q, alu_q_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  err_q, err_d;

    logic [3:0]  mem_op [DEPTH];
    logic [31:0] mem_p  [DEPTH];
    logic [31:0] mem_q  [DEPTH];

    logic empty;
    logic full;
    logic push;

    assign empty = (wr_q == rd_q);
    // Pointers carry one extra wrap bit; full when only that bit differs.
    assign full  = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});

    assign cmd_ready = (state_q == S_IDLE) && !full;
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        alu_op_d = NOP_OP;
        alu_p_d  = '0;
        alu_q_d  = '0;
        done_d   = 1'b0;
        result_d = result_q;
        err_d    = err_q;

        if (push) begin
            wr_d = wr_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CLEAR;
                    alu_op_d = CLR_OP;
                end
            end
            S_CLEAR, S_ISSUE: begin
                // alu_err is only meaningful once a command has been issued;
                // the CLR op itself never reports an error.
                if (state_q == S_ISSUE && alu_err != 2'b00) begin
                    state_d  = S_IDLE;
                    rd_d     = wr_q;
                    result_d = '0;
                    err_d    = alu_err;
                    done_d   = 1'b1;
                end else if (!empty) begin
                    state_d  = S_ISSUE;
                    alu_op_d = mem_op[rd_q[AW-1:0]];
                    alu_p_d  = mem_p[rd_q[AW-1:0]];
                    alu_q_d  = mem_q[rd_q[AW-1:0]];
                    rd_d     = rd_q + 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (alu_err != 2'b00) begin
                    rd_d     = wr_q;
                    result_d = '0;
                    err_d    = alu_err;
                end else begin
                    result_d = alu_out;
                    err_d    = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_q[AW-1:0]] <= cmd_op;
            mem_p[wr_q[AW-1:0]]  <= cmd_p;
            mem_q[wr_q[AW-1:0]]  <= cmd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            alu_op_q <= NOP_OP;
            alu_p_q  <= '0;
            alu_q_q  <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            alu_op_q <= alu_op_d;
            alu_p_q  <= alu_p_d;
            alu_q_q  <= alu_q_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign alu_op = alu_op_q;
    assign alu_p  = alu_p_q;
    assign alu_q  = alu_q_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: scoreboard bench for calc_op_sequencer with a small
// behavioural ALU (1100 clr, 1111 P^Q, 0010 mul, 0011 div, 0001 add).
module tb_calc_op_sequencer;

    localparam int DEPTH = 4;
    localparam logic [3:0] CLR = 4'b1100;
    localparam logic [3:0] NOP = 4'b0000;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] p;
        logic [31:0] q;
    } cmd_t;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [31:0] cmd_p = '0;
    logic [31:0] cmd_q = '0;
    logic        start = 1'b0;
    logic [3:0]  alu_op;
    logic [31:0] alu_p;
    logic [31:0] alu_q;
    logic [31:0] alu_out;
    logic [1:0]  alu_err;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  err;

    int nchk = 0;
    int nerr = 0;
    int cnt = 0;
    int t0 = 0;
    bit mon_en = 1'b1;
    bit prev_done = 1'b0;

    cmd_t mq[$];
    cmd_t exp_ops[$];
    exp_t sb[$];

    logic [31:0] acc;
    logic [1:0]  aerr;

    calc_op_sequencer #(
        .DEPTH(DEPTH),
        .CLR_OP(CLR),
        .NOP_OP(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_p(cmd_p),
        .cmd_q(cmd_q),
        .start(start),
        .alu_op(alu_op),
        .alu_p(alu_p),
        .alu_q(alu_q),
        .alu_out(alu_out),
        .alu_err(alu_err),
        .busy(busy),
        .done(done),
        .result(result),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt++;

    function automatic logic [31:0] pw(input logic [31:0] p,
                                       input logic [31:0] q);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < int'(q[4:0]); i++) r = r * p;
        return r;
    endfunction

    function automatic logic [31:0] acc_next(input logic [3:0] op,
                                             input logic [31:0] p,
                                             input logic [31:0] q,
                                             input logic [31:0] a);
        case (op)
            4'b1100: return 32'd0;
            4'b1111: return pw(p, q);
            4'b0010: return a * p;
            4'b0011: return (p == 0) ? a : a / p;
            4'b0001: return a + p;
            default: return a;
        endcase
    endfunction

    function automatic logic [1:0] err_next(input logic [3:0] op,
                                            input logic [31:0] p);
        return (op == 4'b0011 && p == 0) ? 2'b01 : 2'b00;
    endfunction

    // Behavioural ALU: registered accumulator and error code.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            aerr <= '0;
        end else begin
            acc  <= acc_next(alu_op, alu_p, alu_q, acc);
            aerr <= err_next(alu_op, alu_p);
        end
    end
    assign alu_out = acc;
    assign alu_err = aerr;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: compare issued ops and final outcome against the scoreboard.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (prev_done) chk("done_width", done, 0);
            if (busy) begin
                if (exp_ops.size() == 0) begin
                    chk("op_extra", alu_op, 4'hF);
                end else begin
                    cmd_t e;
                    e = exp_ops.pop_front();
                    chk("alu_op", alu_op, e.op);
                    chk("alu_p", alu_p, e.p);
                    chk("alu_q", alu_q, e.q);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexp", done, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("result", result, x.res);
                    chk("err", err, x.err);
                    chk("latency", cnt - t0 + 1, x.lat);
                    chk("busy_at_done", busy, 0);
                    chk("ops_left", exp_ops.size(), 0);
                end
            end
        end
        prev_done = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [31:0] p,
                            input logic [31:0] q);
        cmd_t c;
        c = '{op, p, q};
        chk("ready_push", cmd_ready, mq.size() < DEPTH);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_p = p;
        cmd_q = q;
        if (mq.size() < DEPTH) mq.push_back(c);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        step();
    endtask

    // Builds the expected op stream and outcome from the queued commands.
    task automatic start_run(input bit wp, input logic [3:0] op,
                             input logic [31:0] p, input logic [31:0] q);
        logic [31:0] a;
        logic [1:0]  e;
        exp_t x;
        bit aborted;
        cmd_t c;
        if (wp) begin
            c = '{op, p, q};
            mq.push_back(c);
            cmd_valid = 1'b1;
            cmd_op = op;
            cmd_p = p;
            cmd_q = q;
        end
        a = '0;
        aborted = 1'b0;
        exp_ops.push_back('{CLR, 32'd0, 32'd0});
        for (int i = 0; i < mq.size(); i++) begin
            exp_ops.push_back(mq[i]);
            e = err_next(mq[i].op, mq[i].p);
            a = acc_next(mq[i].op, mq[i].p, mq[i].q, a);
            if (e != 0) begin
                if (i + 1 < mq.size()) exp_ops.push_back(mq[i+1]);
                else exp_ops.push_back('{NOP, 32'd0, 32'd0});
                x = '{32'd0, e, i + 4};
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            exp_ops.push_back('{NOP, 32'd0, 32'd0});
            x = '{a, 2'b00, mq.size() + 3};
        end
        sb.push_back(x);
        mq.delete();
        start = 1'b1;
        step();
        t0 = cnt;
        start = 1'b0;
        cmd_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        bit saw_done;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_op", alu_op, NOP);
        chk("rst_alu_p", alu_p, 0);
        chk("rst_alu_q", alu_q, 0);
        chk("rst_ready", cmd_ready, 1);

        // Circle area: 12^2 * 3141 / 1000 = 452
        push_cmd(4'b1111, 32'd12, 32'd2);
        push_cmd(4'b0010, 32'd3141, 32'd0);
        push_cmd(4'b0011, 32'd1000, 32'd0);
        start_run(0, NOP, 0, 0);

        // Empty FIFO run
        start_run(0, NOP, 0, 0);

        // Divide by zero on command 2
        push_cmd(4'b0010, 32'd5, 32'd0);
        push_cmd(4'b0011, 32'd0, 32'd0);
        push_cmd(4'b0010, 32'd7, 32'd0);
        start_run(0, NOP, 0, 0);
        chk("flush_ready", cmd_ready, 1);
        start_run(0, NOP, 0, 0);

        // Full FIFO: five held pushes, only four accepted
        for (int i = 1; i <= 5; i++) push_cmd(4'b0001, i, 32'd0);
        chk("full_ready", cmd_ready, 0);
        start_run(0, NOP, 0, 0);

        // Same-edge push and start
        push_cmd(4'b0001, 32'd10, 32'd0);
        start_run(1, 4'b0001, 32'd20, 32'd0);

        // Reset mid-run
        mon_en = 1'b0;
        for (int i = 1; i <= 4; i++) push_cmd(4'b0001, i, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mq.delete();
        exp_ops.delete();
        sb.delete();
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_op", alu_op, NOP);
        chk("mid_rst_ready", cmd_ready, 1);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_no_done", saw_done, 0);
        step();
        mon_en = 1'b1;

        // Fresh run after reset
        push_cmd(4'b0001, 32'd9, 32'd0);
        start_run(0, NOP, 0, 0);

        step();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
